// File: rtl/cond_exec_stage_pkg.sv
// Shared constants for the conditional-execute stage: opcodes, ALU commands,
// condition codes and NZCV flag bit positions.
package cond_exec_stage_pkg;

    localparam logic [1:0] OP_DP  = 2'd0;
    localparam logic [1:0] OP_MEM = 2'd1;
    localparam logic [1:0] OP_BR  = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_RSB = 4'b0011;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition field against NZCV.
module cond_check
    import cond_exec_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n_s, z_s, c_s, v_s;

    assign n_s = nzcv[FLAG_N];
    assign z_s = nzcv[FLAG_Z];
    assign c_s = nzcv[FLAG_C];
    assign v_s = nzcv[FLAG_V];

    // Condition decode; the reserved code never executes.
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z_s;
            COND_NE: pass = ~z_s;
            COND_CS: pass = c_s;
            COND_CC: pass = ~c_s;
            COND_MI: pass = n_s;
            COND_PL: pass = ~n_s;
            COND_VS: pass = v_s;
            COND_VC: pass = ~v_s;
            COND_HI: pass = c_s & ~z_s;
            COND_LS: pass = ~c_s | z_s;
            COND_GE: pass = (n_s == v_s);
            COND_LT: pass = (n_s != v_s);
            COND_GT: pass = ~z_s & (n_s == v_s);
            COND_LE: pass = z_s | (n_s != v_s);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute-stage back end: NZCV register, condition gating of write enables,
// flag commit, valid/ready output register and squashed-instruction counter.
module cond_exec_stage
    import cond_exec_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cond,
    input  logic [1:0]        in_opcode,
    input  logic [3:0]        in_cmd,
    input  logic              in_s,
    input  logic              in_store,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [3:0]        in_alu_flags,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_we,
    output logic              out_mem_we,
    output logic              out_pc_we,
    output logic [3:0]        flags_q,
    output logic [CNT_W-1:0]  squash_cnt
);

    logic              valid_r;
    logic [DATA_W-1:0] result_r;
    logic [REG_AW-1:0] rd_r;
    logic              reg_we_r, mem_we_r, pc_we_r;
    logic [3:0]        flags_r;
    logic [CNT_W-1:0]  squash_cnt_r;

    logic       pass_s, accept_s, flag_wr_s, cv_upd_s;
    logic       reg_we_s, mem_we_s, pc_we_s;
    logic [3:0] flags_nxt_s;

    cond_check u_cond_check (
        .cond (in_cond),
        .nzcv (flags_r),
        .pass (pass_s)
    );

    assign in_ready  = ~valid_r | out_ready;
    assign accept_s  = in_valid & in_ready & ~flush;
    assign flag_wr_s = accept_s & pass_s & (in_opcode == OP_DP) & (in_s | (in_cmd == CMD_CMP));

    // Write-enable decode per opcode, gated by the condition result.
    always_comb begin
        reg_we_s = 1'b0;
        mem_we_s = 1'b0;
        pc_we_s  = 1'b0;
        case (in_opcode)
            OP_DP:  reg_we_s = pass_s & (in_cmd != CMD_CMP);
            OP_MEM: begin
                mem_we_s = pass_s & in_store;
                reg_we_s = pass_s & ~in_store;
            end
            OP_BR:  pc_we_s = pass_s;
            OP_ILL: pc_we_s = 1'b0;
            default: pc_we_s = 1'b0;
        endcase
    end

    // Only arithmetic commands produce meaningful carry/overflow.
    always_comb begin
        cv_upd_s = 1'b0;
        case (in_cmd)
            CMD_SUB, CMD_RSB, CMD_ADD, CMD_CMP: cv_upd_s = 1'b1;
            default: cv_upd_s = 1'b0;
        endcase
    end

    // Next NZCV: N/Z always from the ALU on commit, C/V only for arithmetic.
    always_comb begin
        flags_nxt_s = flags_r;
        if (flag_wr_s) begin
            flags_nxt_s[FLAG_N] = in_alu_flags[FLAG_N];
            flags_nxt_s[FLAG_Z] = in_alu_flags[FLAG_Z];
            if (cv_upd_s) begin
                flags_nxt_s[FLAG_C] = in_alu_flags[FLAG_C];
                flags_nxt_s[FLAG_V] = in_alu_flags[FLAG_V];
            end else begin
                flags_nxt_s[FLAG_C] = flags_r[FLAG_C];
                flags_nxt_s[FLAG_V] = flags_r[FLAG_V];
            end
        end else begin
            flags_nxt_s = flags_r;
        end
    end

    // Output pipeline register; flush beats both accept and drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r  <= 1'b0;
            result_r <= {DATA_W{1'b0}};
            rd_r     <= {REG_AW{1'b0}};
            reg_we_r <= 1'b0;
            mem_we_r <= 1'b0;
            pc_we_r  <= 1'b0;
        end else if (flush) begin
            valid_r  <= 1'b0;
            reg_we_r <= 1'b0;
            mem_we_r <= 1'b0;
            pc_we_r  <= 1'b0;
        end else if (accept_s) begin
            valid_r  <= 1'b1;
            result_r <= in_alu_out;
            rd_r     <= in_rd;
            reg_we_r <= reg_we_s;
            mem_we_r <= mem_we_s;
            pc_we_r  <= pc_we_s;
        end else if (valid_r && out_ready) begin
            valid_r  <= 1'b0;
            reg_we_r <= 1'b0;
            mem_we_r <= 1'b0;
            pc_we_r  <= 1'b0;
        end
    end

    // Architectural flags and saturating squash counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r      <= 4'b0000;
            squash_cnt_r <= {CNT_W{1'b0}};
        end else begin
            flags_r <= flags_nxt_s;
            if (accept_s && !pass_s && !(&squash_cnt_r)) begin
                squash_cnt_r <= squash_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid  = valid_r;
    assign out_result = result_r;
    assign out_rd     = rd_r;
    assign out_reg_we = reg_we_r;
    assign out_mem_we = mem_we_r;
    assign out_pc_we  = pc_we_r;
    assign flags_q    = flags_r;
    assign squash_cnt = squash_cnt_r;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed plus randomized bench for cond_exec_stage against a cycle-level
// behavioural model of the stage.
module tb_cond_exec_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_cond = 4'h0;
    logic [1:0]        in_opcode = 2'd0;
    logic [3:0]        in_cmd = 4'h0;
    logic              in_s = 1'b0;
    logic              in_store = 1'b0;
    logic [DATA_W-1:0] in_alu_out = '0;
    logic [3:0]        in_alu_flags = 4'h0;
    logic [REG_AW-1:0] in_rd = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_result;
    logic [REG_AW-1:0] out_rd;
    logic              out_reg_we, out_mem_we, out_pc_we;
    logic [3:0]        flags_q;
    logic [CNT_W-1:0]  squash_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_valid = 1'b0;
    logic [31:0] m_result = '0;
    logic [3:0]  m_rd = '0;
    bit          m_reg = 1'b0, m_mem = 1'b0, m_pc = 1'b0;
    logic [3:0]  m_flags = 4'h0;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    cond_exec_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_cond(in_cond), .in_opcode(in_opcode), .in_cmd(in_cmd), .in_s(in_s),
        .in_store(in_store), .in_alu_out(in_alu_out), .in_alu_flags(in_alu_flags),
        .in_rd(in_rd), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_reg_we(out_reg_we),
        .out_mem_we(out_mem_we), .out_pc_we(out_pc_we), .flags_q(flags_q),
        .squash_cnt(squash_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_edge();
        bit rdy, acc, p;
        rdy = !m_valid || out_ready;
        acc = in_valid && rdy && !flush;
        p   = cond_ok(in_cond, m_flags);
        if (flush) begin
            m_valid = 0; m_reg = 0; m_mem = 0; m_pc = 0;
        end else if (acc) begin
            m_valid  = 1;
            m_result = in_alu_out;
            m_rd     = in_rd;
            m_reg = p && ((in_opcode == 2'd0 && in_cmd != 4'hA) || (in_opcode == 2'd1 && !in_store));
            m_mem = p && in_opcode == 2'd1 && in_store;
            m_pc  = p && in_opcode == 2'd2;
        end else if (m_valid && out_ready) begin
            m_valid = 0; m_reg = 0; m_mem = 0; m_pc = 0;
        end
        if (acc && p && in_opcode == 2'd0 && (in_s || in_cmd == 4'hA)) begin
            m_flags[3:2] = in_alu_flags[3:2];
            if (in_cmd == 4'h2 || in_cmd == 4'h3 || in_cmd == 4'h4 || in_cmd == 4'hA)
                m_flags[1:0] = in_alu_flags[1:0];
        end
        if (acc && !p && m_cnt < 65535) m_cnt++;
    endtask

    task automatic compare_outputs();
        chk("out_valid",  64'(out_valid),  64'(m_valid));
        chk("out_result", 64'(out_result), 64'(m_result));
        chk("out_rd",     64'(out_rd),     64'(m_rd));
        chk("out_reg_we", 64'(out_reg_we), 64'(m_reg));
        chk("out_mem_we", 64'(out_mem_we), 64'(m_mem));
        chk("out_pc_we",  64'(out_pc_we),  64'(m_pc));
        chk("flags_q",    64'(flags_q),    64'(m_flags));
        chk("squash_cnt", 64'(squash_cnt), 64'(m_cnt));
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic step();
        #1;
        chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] c, input logic [1:0] op, input logic [3:0] cmd,
                        input logic s, input logic st, input logic [31:0] alu,
                        input logic [3:0] fl, input logic [3:0] rd);
        in_valid = 1'b1; in_cond = c; in_opcode = op; in_cmd = cmd; in_s = s;
        in_store = st; in_alu_out = alu; in_alu_flags = fl; in_rd = rd;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        #2;
        compare_outputs();
        chk("reset_flags", 64'(flags_q), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // CMP sets flags without writing a register
        send(4'hE, 2'd0, 4'hA, 1'b0, 1'b0, 32'h0, 4'b0100, 4'd1);
        chk("cmp_flags", 64'(flags_q), 64'h4);
        chk("cmp_reg_we", 64'(out_reg_we), 64'h0);
        // NE fails with Z=1, EQ passes
        send(4'h1, 2'd0, 4'h4, 1'b0, 1'b0, 32'h5, 4'h0, 4'd2);
        chk("ne_squash", 64'(squash_cnt), 64'h1);
        send(4'h0, 2'd0, 4'h4, 1'b0, 1'b0, 32'h5, 4'h0, 4'd2);
        chk("eq_reg_we", 64'(out_reg_we), 64'h1);
        chk("eq_result", 64'(out_result), 64'h5);
        // Logical op keeps C/V, arithmetic op takes them
        send(4'hE, 2'd0, 4'hA, 1'b0, 1'b0, 32'h0, 4'h0, 4'd0);
        send(4'hE, 2'd0, 4'h0, 1'b1, 1'b0, 32'h1, 4'b1011, 4'd3);
        chk("and_flags", 64'(flags_q), 64'h8);
        send(4'hE, 2'd0, 4'h2, 1'b1, 1'b0, 32'h2, 4'b1011, 4'd3);
        chk("sub_flags", 64'(flags_q), 64'hB);
        // Stall for three cycles then back-to-back transfer
        idle();
        out_ready = 1'b0;
        send(4'hE, 2'd0, 4'h4, 1'b0, 1'b0, 32'h77, 4'h0, 4'd3);
        for (int i = 0; i < 3; i++) begin
            send(4'hE, 2'd0, 4'h4, 1'b0, 1'b0, 32'h88, 4'h0, 4'd4);
            chk("stall_ready", 64'(in_ready), 64'h0);
            chk("stall_result", 64'(out_result), 64'h77);
        end
        out_ready = 1'b1;
        send(4'hE, 2'd0, 4'h4, 1'b0, 1'b0, 32'h88, 4'h0, 4'd4);
        chk("b2b_valid", 64'(out_valid), 64'h1);
        chk("b2b_result", 64'(out_result), 64'h88);
        // Branch then flush with an incoming flag-setting instruction
        send(4'hE, 2'd2, 4'h0, 1'b0, 1'b0, 32'h400, 4'h0, 4'd0);
        chk("br_pc_we", 64'(out_pc_we), 64'h1);
        flush = 1'b1;
        send(4'hE, 2'd0, 4'hA, 1'b0, 1'b0, 32'h0, 4'hF, 4'd0);
        flush = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'h0);
        chk("flush_flags", 64'(flags_q), 64'hB);
        // Store under GE with N=V=1, then a never-executing load
        send(4'hE, 2'd0, 4'h2, 1'b1, 1'b0, 32'h0, 4'b1001, 4'd0);
        send(4'hA, 2'd1, 4'h0, 1'b0, 1'b1, 32'h100, 4'h0, 4'd5);
        chk("st_mem_we", 64'(out_mem_we), 64'h1);
        chk("st_reg_we", 64'(out_reg_we), 64'h0);
        send(4'hF, 2'd1, 4'h0, 1'b0, 1'b0, 32'h104, 4'h0, 4'd6);
        chk("nv_enables", 64'({out_reg_we, out_mem_we, out_pc_we}), 64'h0);
        chk("nv_squash", 64'(squash_cnt), 64'h2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 7) == 0);
            out_ready    = ($urandom_range(0, 3) != 0);
            in_cond      = 4'($urandom_range(0, 15));
            in_opcode    = 2'($urandom_range(0, 3));
            in_cmd       = 4'($urandom_range(0, 15));
            in_s         = 1'($urandom_range(0, 1));
            in_store     = 1'($urandom_range(0, 1));
            in_alu_out   = $urandom;
            in_alu_flags = 4'($urandom_range(0, 15));
            in_rd        = 4'($urandom_range(0, 15));
            step();
        end
        flush = 1'b0;

        // Asynchronous reset while an instruction is held
        out_ready = 1'b1;
        idle();
        out_ready = 1'b0;
        send(4'hE, 2'd0, 4'hA, 1'b0, 1'b0, 32'h9, 4'hF, 4'd7);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m_valid = 0; m_result = '0; m_rd = '0; m_reg = 0; m_mem = 0; m_pc = 0;
        m_flags = 4'h0; m_cnt = 0;
        compare_outputs();
        chk("rst_valid", 64'(out_valid), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cond_exec_stage.md
Name: cond_exec_stage

Overview:
- Execute-stage back end that sits directly downstream of the ALU.
- Holds the architectural NZCV status register and evaluates each instruction's 4-bit condition field against it.
- Commits ALU flags under S-bit/CMP rules.
- Registers the ALU result together with gated write enables into a valid/ready pipeline register that feeds memory/writeback.
- Counts condition-failed instructions for performance monitoring.

Parameters:
DATA_W, 32, datapath width (ALU result width)
REG_AW, 4, register-file address width
CNT_W, 16, width of the squashed-instruction counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream instruction/ALU result valid
in_ready  output  1  stage can accept this cycle
in_cond  input  4  condition field
in_opcode  input  2  0=data-processing, 1=memory, 2=branch, 3=illegal
in_cmd  input  4  ALU command
in_s  input  1  set-flags bit
in_store  input  1  memory op is store (1) or load (0)
in_alu_out  input  DATA_W  ALU result
in_alu_flags  input  4  ALU flags; [3]=N [2]=Z [1]=C [0]=V
in_rd  input  REG_AW  destination register
flush  input  1  squash the held and the incoming instruction (taken branch)
out_valid  output  1  stage register valid
out_ready  input  1  downstream accepts
out_result  output  DATA_W  registered ALU result
out_rd  output  REG_AW  registered destination
out_reg_we  output  1  register-file write enable
out_mem_we  output  1  memory write enable
out_pc_we  output  1  PC write (branch taken)
flags_q  output  4  architectural NZCV
squash_cnt  output  CNT_W  saturating count of condition-failed instructions

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_result=0, out_rd=0, all enables=0, flags_q=4'b0000, squash_cnt=0. Reset mid-transfer discards the held instruction.
- in_ready = !out_valid | out_ready (combinational). accept = in_valid & in_ready & !flush.
- Condition evaluation is combinational on flags_q (N,Z,C,V):
  - 0 EQ: Z; 1 NE: !Z; 2 CS: C; 3 CC: !C; 4 MI: N; 5 PL: !N; 6 VS: V; 7 VC: !V
  - 8 HI: C&!Z; 9 LS: !C|Z; A GE: N==V; B LT: N!=V; C GT: !Z&(N==V); D LE: Z|(N!=V)
  - E AL: 1; F: 0 (reserved, never executes)
- Enables, all gated by pass:
  - opcode 0: reg_we = pass & (cmd != 4'b1010).
  - opcode 1: mem_we = pass & store; reg_we = pass & !store.
  - opcode 2: pc_we = pass.
  - opcode 3: all enables 0.
- Flag commit on accept & pass & opcode==0 & (in_s | cmd==4'b1010):
  - N and Z are always taken from in_alu_flags.
  - C and V are taken only when cmd is one of 0010, 0011, 0100, 1010; otherwise they hold.
  - No flag writes for opcodes 1–3.
- The next instruction accepted (at the earliest, the following cycle) sees the updated flags_q. No bypass is needed.
- Condition-failed instructions are still accepted and forwarded as bubbles (out_valid=1, all enables 0, result/rd still captured) to keep ordering.
- squash_cnt increments on accept & !pass and saturates at all-ones.
- Stage register: on accept, capture result/rd/enables and set out_valid=1. Otherwise, if out_valid & out_ready, clear out_valid (data fields hold, enables cleared). Otherwise hold, which covers stall (out_valid & !out_ready).
- Latency: 1 cycle from accept to out_valid.
- flush: clears out_valid and all enables next edge. The incoming instruction is dropped: no flag update, no count. flush overrides a simultaneous accept and handshake.
- Simultaneous out handshake and accept: the new instruction replaces the old one; out_valid stays 1.

Decomposition:
- Shared package:
  - opcode constants OP_DP/OP_MEM/OP_BR.
  - cmd constants CMD_AND, CMD_EOR, CMD_SUB, CMD_RSB, CMD_ADD, CMD_CMP, CMD_ORR.
  - condition-code constants COND_EQ..COND_NV.
  - flag bit indices FLAG_N/Z/C/V.
- One natural sub-module: cond_check, purely combinational (cond, nzcv) -> pass.

Test Plan:
- Reset then CMP (opcode 0, cmd 1010, s=0) with alu_flags=4'b0100 → flags_q=4'b0100 next cycle, out_reg_we=0, out_valid=1.
- flags_q Z=1; ADD with cond NE, alu_out=32'h5 → out_valid=1, out_reg_we=0, squash_cnt 0→1, flags_q unchanged. Same instruction with cond EQ → out_reg_we=1, out_result=32'h5.
- AND with s=1, alu_flags=4'b1011, prior flags_q=4'b0000 → flags_q=4'b1000 (C,V held). SUB with s=1, same flags → flags_q=4'b1011.
- Hold out_ready=0 for 3 cycles with out_valid=1 → in_ready=0, outputs stable. Then out_ready=1 together with a new in_valid → back-to-back transfer, out_valid stays 1.
- Branch (opcode 2, cond AL) accepted, then flush asserted with in_valid=1 → out_valid=0 next cycle, no flag change, squash_cnt unchanged.
- Store (opcode 1, store=1, cond GE with N=V=1) → out_mem_we=1, out_reg_we=0. Load with cond 4'hF → all enables 0, squash_cnt increments.
